// File: rtl/fifo_stream_reader_pkg.sv
// Shared queue-path package: width defaults, skid depth,
// checker state type and a skid occupancy helper.
package fifo_stream_reader_pkg;

  localparam int DW_DEF     = 16;
  localparam int CW_DEF     = 16;
  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] skid_cnt_t;

  typedef enum logic {
    CHK_SEED = 1'b0,
    CHK_RUN  = 1'b1
  } chk_state_t;

  // Words the buffer will hold after this edge if no new
  // read is issued: held + arriving - leaving.
  function automatic logic [2:0] skid_level(
    input skid_cnt_t cnt,
    input logic      inflight,
    input logic      pop
  );
    return {1'b0, cnt}
         + {2'b00, inflight}
         - {2'b00, pop};
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port + valid/ready output stream bundle.
// master: reader side; slave: FIFO + downstream side.
interface fifo_stream_reader_if #(
  parameter int DW = 16
);

  logic          fifo_rd_en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;

  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_rd_data,
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_rd_data,
    input  m_valid,
    input  m_data,
    output m_ready
  );

endinterface

// File: rtl/fifo_stream_reader_skid_buf2.sv
// skid_buf2: 2-entry register FIFO (push, pop, cnt, head).
// Ports: clk, rst_n, i_push, i_din, i_pop, o_cnt, o_head.
module skid_buf2
  import fifo_stream_reader_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_din,
  input  logic          i_pop,
  output skid_cnt_t     o_cnt,
  output logic [DW-1:0] o_head
);

  skid_cnt_t     r_cnt;
  logic [DW-1:0] r_d0;
  logic [DW-1:0] r_d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_d0  <= '0;
      r_d1  <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_d0 <= i_din;
          else               r_d1 <= i_din;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_d0  <= r_d1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          // new word queues behind whatever stays
          if (r_cnt == 2'd1) begin
            r_d0 <= i_din;
          end else begin
            r_d0 <= r_d1;
            r_d1 <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_cnt  = r_cnt;
  assign o_head = r_d0;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side companion to sync_fifo: issues reads, skid-buffers
// the late data, streams it out and checks for +1 sequence.
// Ports: clk, rst_n, rd_enable, seq_clr, seq_err, err_cnt,
//        bus (fifo_rd_en/empty/rd_data, m_valid/data/ready).
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int CW        = CW_DEF,
  parameter bit CHECK_SEQ = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rd_enable,
  input  logic                 seq_clr,
  output logic                 seq_err,
  output logic [CW-1:0]        err_cnt,
  fifo_stream_reader_if.master bus
);

  logic          r_armed;
  logic          r_inflight;
  skid_cnt_t     w_cnt;
  logic [DW-1:0] w_head;
  logic          w_valid;
  logic          w_pop;
  logic [2:0]    w_level;

  assign w_valid = (w_cnt != 2'd0);
  assign w_pop   = w_valid && bus.m_ready;
  assign w_level = skid_level(w_cnt, r_inflight, w_pop);

  // r_armed keeps reads off while rst_n is low, so
  // nothing is taken from the FIFO and then dropped.
  assign bus.fifo_rd_en = r_armed
                       && rd_enable
                       && !bus.fifo_empty
                       && (w_level < 3'(SKID_DEPTH));

  assign bus.m_valid = w_valid;
  assign bus.m_data  = w_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed    <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_armed    <= 1'b1;
      r_inflight <= bus.fifo_rd_en;
    end
  end

  skid_buf2 #(
    .DW(DW)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .i_push(r_inflight),
    .i_din (bus.fifo_rd_data),
    .i_pop (w_pop),
    .o_cnt (w_cnt),
    .o_head(w_head)
  );

  if (CHECK_SEQ) begin : g_chk
    chk_state_t    r_state;
    logic [DW-1:0] r_exp;
    logic          r_err;
    logic [CW-1:0] r_ecnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= CHK_SEED;
        r_exp   <= '0;
        r_err   <= 1'b0;
        r_ecnt  <= '0;
      end else if (seq_clr) begin
        r_state <= CHK_SEED;
        r_err   <= 1'b0;
        r_ecnt  <= '0;
      end else if (w_pop) begin
        // always resync: one error per discontinuity
        r_state <= CHK_RUN;
        r_exp   <= w_head + DW'(1);
        if (r_state == CHK_RUN && w_head != r_exp) begin
          r_err <= 1'b1;
          if (r_ecnt != '1) r_ecnt <= r_ecnt + CW'(1);
        end else begin
          r_err <= 1'b0;
        end
      end else begin
        r_err <= 1'b0;
      end
    end

    assign seq_err = r_err;
    assign err_cnt = r_ecnt;
  end else begin : g_nochk
    assign seq_err = 1'b0;
    assign err_cnt = '0;
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench: sync_fifo read model + scoreboard around
// fifo_stream_reader; one task per scenario.
module tb_fifo_stream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     = 1'b1;
  logic        rd_enable = 1'b0;
  logic        seq_clr   = 1'b0;
  logic        m_ready   = 1'b0;
  logic        seq_err;
  logic [15:0] err_cnt;

  fifo_stream_reader_if #(.DW(16)) bus();

  logic        f_empty = 1'b1;
  logic [15:0] f_rdata = '0;
  assign bus.fifo_empty   = f_empty;
  assign bus.fifo_rd_data = f_rdata;
  assign bus.m_ready      = m_ready;

  fifo_stream_reader #(
    .DW(16),
    .CW(16),
    .CHECK_SEQ(1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_enable(rd_enable),
    .seq_clr  (seq_clr),
    .seq_err  (seq_err),
    .err_cnt  (err_cnt),
    .bus      (bus)
  );

  logic [15:0] mem[$];
  logic [15:0] exp_q[$];
  int          rd_count = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  // sync_fifo read side: registered empty, data one cycle late
  always @(posedge clk) begin
    if (bus.fifo_rd_en && !f_empty) begin
      f_rdata <= mem.pop_front();
      rd_count++;
    end
    f_empty <= (mem.size() == 0);
  end

  task automatic load(input logic [15:0] v);
    mem.push_back(v);
    exp_q.push_back(v);
  endtask

  task automatic clr();
    seq_clr = 1'b1;
    @(negedge clk);
    seq_clr = 1'b0;
  endtask

  task automatic flush();
    rd_enable = 1'b0;
    m_ready   = 1'b0;
    repeat (3) @(negedge clk);
    mem.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (100) @(negedge clk);
    n_chk++;
    if (bus.fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_rd_en got=%b exp=0", bus.fifo_rd_en);
    end
    n_chk++;
    if (bus.m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid got=%b exp=0", bus.m_valid);
    end
    n_chk++;
    if (bus.m_data !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_data got=%h exp=0", bus.m_data);
    end
    n_chk++;
    if (seq_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_seq_err got=%b exp=0", seq_err);
    end
    n_chk++;
    if (err_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL rst_err_cnt got=%0d exp=0", err_cnt);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stream();
    int lat = 0;
    int first = -1;
    int last = -1;
    int errs = 0;
    logic [15:0] e;
    clr();
    for (int v = 1; v <= 8; v++) load(16'(v));
    rd_enable = 1'b1;
    m_ready   = 1'b1;
    while (!bus.m_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_chk++;
    if (lat !== 3) begin
      n_fail++;
      $display("FAIL stream_latency got=%0d exp=3", lat);
    end
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (seq_err) errs++;
      if (bus.m_valid && m_ready) begin
        e = exp_q.pop_front();
        n_chk++;
        if (bus.m_data !== e) begin
          n_fail++;
          $display("FAIL stream_data got=%h exp=%h",
                   bus.m_data, e);
        end
        if (first < 0) first = c;
        last = c;
      end
      @(negedge clk);
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_timeout left=%0d exp=0",
               exp_q.size());
    end
    n_chk++;
    if (last - first !== 7) begin
      n_fail++;
      $display("FAIL stream_gapless span=%0d exp=7",
               last - first);
    end
    repeat (2) begin
      if (seq_err) errs++;
      @(negedge clk);
    end
    n_chk++;
    if (errs !== 0 || err_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL stream_seq errs=%0d cnt=%0d exp=0/0",
               errs, err_cnt);
    end
    flush();
  endtask

  task automatic test_backpressure();
    int rd0;
    int bad = 0;
    int first = -1;
    int last = -1;
    logic [15:0] e;
    clr();
    rd0 = rd_count;
    for (int v = 1; v <= 10; v++) load(16'(v));
    m_ready   = 1'b0;
    rd_enable = 1'b1;
    repeat (8) @(negedge clk);
    for (int c = 0; c < 8; c++) begin
      if (!bus.m_valid || bus.m_data !== 16'd1) bad++;
      @(negedge clk);
    end
    n_chk++;
    if (rd_count - rd0 !== 2) begin
      n_fail++;
      $display("FAIL bp_reads got=%0d exp=2", rd_count - rd0);
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL bp_hold bad=%0d exp=0 data=%h",
               bad, bus.m_data);
    end
    n_chk++;
    if (bus.fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_rd_en got=%b exp=0", bus.fifo_rd_en);
    end
    m_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (bus.m_valid && m_ready) begin
        e = exp_q.pop_front();
        n_chk++;
        if (bus.m_data !== e) begin
          n_fail++;
          $display("FAIL bp_data got=%h exp=%h", bus.m_data, e);
        end
        if (first < 0) first = c;
        last = c;
      end
      @(negedge clk);
    end
    n_chk++;
    if (exp_q.size() != 0 || last - first !== 9) begin
      n_fail++;
      $display("FAIL bp_drain left=%0d span=%0d exp=0/9",
               exp_q.size(), last - first);
    end
    flush();
  endtask

  task automatic test_seq_skip();
    int prev = -1;
    int pulses = 0;
    int err_word = -1;
    int tail = 0;
    logic [15:0] e;
    clr();
    load(16'd5);
    load(16'd6);
    load(16'd8);
    load(16'd9);
    rd_enable = 1'b1;
    m_ready   = 1'b1;
    for (int c = 0; c < 40 && tail < 3; c++) begin
      if (seq_err) begin
        pulses++;
        err_word = prev;
      end
      prev = -1;
      if (bus.m_valid && m_ready) begin
        e = exp_q.pop_front();
        n_chk++;
        if (bus.m_data !== e) begin
          n_fail++;
          $display("FAIL skip_data got=%h exp=%h",
                   bus.m_data, e);
        end
        prev = int'(bus.m_data);
      end
      if (exp_q.size() == 0) tail++;
      @(negedge clk);
    end
    n_chk++;
    if (pulses !== 1 || err_word !== 8) begin
      n_fail++;
      $display("FAIL skip_pulse n=%0d word=%0d exp=1/8",
               pulses, err_word);
    end
    n_chk++;
    if (err_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL skip_cnt got=%0d exp=1", err_cnt);
    end
    flush();
  endtask

  task automatic test_wrap();
    int pulses = 0;
    int tail = 0;
    logic [15:0] e;
    clr();
    n_chk++;
    if (err_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL clr_cnt got=%0d exp=0", err_cnt);
    end
    load(16'hFFFE);
    load(16'hFFFF);
    load(16'h0000);
    rd_enable = 1'b1;
    m_ready   = 1'b1;
    for (int c = 0; c < 40 && tail < 3; c++) begin
      if (seq_err) pulses++;
      if (bus.m_valid && m_ready) begin
        e = exp_q.pop_front();
        n_chk++;
        if (bus.m_data !== e) begin
          n_fail++;
          $display("FAIL wrap_data got=%h exp=%h",
                   bus.m_data, e);
        end
      end
      if (exp_q.size() == 0) tail++;
      @(negedge clk);
    end
    n_chk++;
    if (pulses !== 0 || err_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL wrap_err n=%0d cnt=%0d exp=0/0",
               pulses, err_cnt);
    end
    flush();
  endtask

  task automatic test_rd_enable_drop();
    int rd0;
    int snap;
    int pops = 0;
    int bad_rd = 0;
    logic [15:0] e;
    clr();
    rd0 = rd_count;
    for (int v = 1; v <= 20; v++) load(16'(v));
    rd_enable = 1'b1;
    m_ready   = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (bus.m_valid && m_ready) begin
        e = exp_q.pop_front();
        n_chk++;
        if (bus.m_data !== e) begin
          n_fail++;
          $display("FAIL drop_data got=%h exp=%h",
                   bus.m_data, e);
        end
        pops++;
      end
      if (pops == 3) break;
      @(negedge clk);
    end
    rd_enable = 1'b0;
    snap = rd_count - rd0;
    #1;
    n_chk++;
    if (bus.fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_rd_en got=%b exp=0", bus.fifo_rd_en);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.fifo_rd_en) bad_rd++;
      if (bus.m_valid && m_ready) begin
        e = exp_q.pop_front();
        n_chk++;
        if (bus.m_data !== e) begin
          n_fail++;
          $display("FAIL drop_data got=%h exp=%h",
                   bus.m_data, e);
        end
        pops++;
      end
    end
    n_chk++;
    if (pops !== snap || rd_count - rd0 !== snap) begin
      n_fail++;
      $display("FAIL drop_count pops=%0d rd=%0d exp=%0d",
               pops, rd_count - rd0, snap);
    end
    n_chk++;
    if (bus.m_valid !== 1'b0 || bad_rd !== 0) begin
      n_fail++;
      $display("FAIL drop_idle valid=%b rd=%0d exp=0/0",
               bus.m_valid, bad_rd);
    end
    flush();
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    int tail = 0;
    logic [15:0] e;
    clr();
    for (int v = 1; v <= 20; v++)
      if (v != 3) load(16'(v));
    rd_enable = 1'b1;
    m_ready   = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (err_cnt == 16'd1) break;
      if (bus.m_valid && m_ready) begin
        e = exp_q.pop_front();
        n_chk++;
        if (bus.m_data !== e) begin
          n_fail++;
          $display("FAIL rmid_data got=%h exp=%h",
                   bus.m_data, e);
        end
      end
      @(negedge clk);
    end
    n_chk++;
    if (err_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL rmid_pre_cnt got=%0d exp=1", err_cnt);
    end
    m_ready = 1'b0;
    rst_n   = 1'b0;
    #1;
    n_chk++;
    if (bus.m_valid !== 1'b0 || err_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL rmid_clear valid=%b cnt=%0d exp=0/0",
               bus.m_valid, err_cnt);
    end
    n_chk++;
    if (bus.m_data !== 16'h0 || bus.fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_out data=%h rd_en=%b exp=0/0",
               bus.m_data, bus.fifo_rd_en);
    end
    // buffered and in-flight words are lost; FIFO keeps the rest
    exp_q = mem;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_ready = 1'b1;
    for (int c = 0; c < 60 && tail < 3; c++) begin
      if (seq_err) pulses++;
      if (bus.m_valid && m_ready) begin
        e = exp_q.pop_front();
        n_chk++;
        if (bus.m_data !== e) begin
          n_fail++;
          $display("FAIL rmid_data got=%h exp=%h",
                   bus.m_data, e);
        end
      end
      if (exp_q.size() == 0) tail++;
      @(negedge clk);
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rmid_timeout left=%0d exp=0",
               exp_q.size());
    end
    n_chk++;
    if (pulses !== 0 || err_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL rmid_seed n=%0d cnt=%0d exp=0/0",
               pulses, err_cnt);
    end
    flush();
  endtask

  initial begin
    #2 rst_n = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_seq_skip();
    test_wrap();
    test_rd_enable_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
